// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and load/store (D).
// Define MEM_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts with err and 0xDEADBEEF data.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_d_q;  // 1: data port owns the current access
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic [StarveW-1:0]  starve_cnt_q;
    logic                any_req, starve_hit, grant_data, grant, abort;

    assign any_req    = if_req | d_req;
    assign starve_hit = (starve_cnt_q == StarveW'(STARVE_LIMIT));
    assign grant_data = d_req & ~(starve_hit & if_req);
    assign grant      = (state_q == StIdle) & any_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StBusy;
            StBusy:  if (mem_ack || abort) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == StBusy);
        if_ready = (state_q == StResp) & ~owner_d_q;
        d_ready  = (state_q == StResp) & owner_d_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_d_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (grant) begin
                owner_d_q   <= grant_data;
                mem_we_q    <= grant_data & d_we;
                mem_addr_q  <= grant_data ? d_addr : if_addr;
                mem_wdata_q <= grant_data ? d_wdata : '0;
            end
            // Fetch starvation: count data wins only while fetch is actually waiting.
            if (state_q == StIdle) begin
                if (!if_req || !grant_data) begin
                    starve_cnt_q <= '0;
                end else if (!starve_hit) begin
                    starve_cnt_q <= starve_cnt_q + StarveW'(1);
                end
            end
            if (state_q == StBusy && mem_ack) begin
                if (owner_d_q) begin
                    d_rdata_q <= mem_we_q ? '0 : mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end else if (abort) begin
                if (owner_d_q) begin
                    d_rdata_q <= DATA_W'(32'hDEAD_BEEF);
                end else begin
                    if_rdata_q <= DATA_W'(32'hDEAD_BEEF);
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            err_q;

    assign abort = (state_q == StBusy) & ~mem_ack & (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q     <= abort;
            tmo_cnt_q <= (state_q == StBusy) ? tmo_cnt_q + TmoW'(1) : '0;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ready;
    assign d_stall   = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned STARVE_LIMIT   = 8;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              err;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one access in flight at a time, completion reported one cycle later.
    bit          m_valid = 0;
    bit          m_inflight, m_done, m_owner_d, m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    int          m_starve, m_busy_cycles;

    task automatic model_step();
        m_valid = 1;
        m_err   = 0;
        if (!reset) begin
            m_inflight = 0; m_done = 0; m_owner_d = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
            m_starve = 0; m_busy_cycles = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_inflight) begin
            if (mem_ack) begin
                if (m_owner_d) m_d_rdata = m_we ? 32'h0 : mem_rdata;
                else m_if_rdata = mem_rdata;
                m_inflight = 0;
                m_done = 1;
            end else begin
                m_busy_cycles++;
`ifdef MEM_ARB_TIMEOUT_EN
                if (m_busy_cycles == TIMEOUT_CYCLES) begin
                    if (m_owner_d) m_d_rdata = 32'hDEAD_BEEF;
                    else m_if_rdata = 32'hDEAD_BEEF;
                    m_inflight = 0;
                    m_done = 1;
                    m_err = 1;
                end
`endif
            end
        end else if (if_req || d_req) begin
            bit pick_d;
            pick_d        = d_req && !(if_req && m_starve >= STARVE_LIMIT);
            m_owner_d     = pick_d;
            m_we          = pick_d && d_we;
            m_addr        = pick_d ? d_addr : if_addr;
            m_wdata       = d_wdata;
            m_inflight    = 1;
            m_busy_cycles = 0;
            if (pick_d && if_req) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else m_starve = 0;
        end else begin
            m_starve = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("mem_req", mem_req, m_inflight);
            if (m_inflight) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", mem_we, m_we);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("if_ready", if_ready, m_done && !m_owner_d);
            check("d_ready", d_ready, m_done && m_owner_d);
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            check("if_stall", if_stall, if_req && !(m_done && !m_owner_d));
            check("d_stall", d_stall, d_req && !(m_done && m_owner_d));
            check("err", err, m_err);
        end
    end

    int  d_grants;
    bit  got_if, got_err;
    int  busy_cnt;
    bit  if_pend, d_pend;

    initial begin
        // Reset held with live request and ack: nothing may leave the arbiter.
        if_req = 1; if_addr = 32'h40; mem_ack = 1;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        #1 reset = 1; if_req = 0; mem_ack = 0;

        // Zero-wait fetch.
        @(negedge clk);
        #1 if_req = 1; if_addr = 32'h10; mem_ack = 1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        check("zw_mem_req", mem_req, 1);
        check("zw_mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        check("zw_if_ready", if_ready, 1);
        check("zw_if_rdata", if_rdata, 32'h0050_0093);
        check("zw_mem_req_drop", mem_req, 0);
        #1 if_req = 0; mem_ack = 0;
        @(negedge clk);
        check("zw_if_ready_pulse", if_ready, 0);

        // Simultaneous requests: data first, then fetch.
        #1 if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("both_addr_d", mem_addr, 32'h100);
        check("both_if_stall", if_stall, 1);
        @(negedge clk);
        check("both_d_ready", d_ready, 1);
        check("both_d_rdata", d_rdata, 32'h1234_5678);
        check("both_d_stall", d_stall, 0);
        #1 d_req = 0; mem_rdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
        check("both_addr_if", mem_addr, 32'h44);
        @(negedge clk);
        check("both_if_ready", if_ready, 1);
        check("both_if_rdata", if_rdata, 32'h0BAD_F00D);
        check("both_d_rdata_held", d_rdata, 32'h1234_5678);
        #1 if_req = 0;

        // Continuous data traffic starving a pending fetch.
        @(negedge clk);
        #1 d_req = 1; d_we = 0; d_addr = 32'h200; if_req = 1; if_addr = 32'h80; mem_ack = 1;
        d_grants = 0; got_if = 0;
        for (int i = 0; i < 100 && !got_if; i++) begin
            @(negedge clk);
            if (if_ready) got_if = 1;
            else if (d_ready) begin
                d_grants++;
                #1 d_addr = d_addr + 4;
            end
        end
        check("starve_if_granted", got_if, 1);
        check("starve_d_grants", d_grants, STARVE_LIMIT);
        #1 d_req = 0; if_req = 0; mem_ack = 0;

        // Store with a three-cycle memory.
        @(negedge clk);
        #1 d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hCAFE; mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_mem_req", mem_req, 1);
            check("st_mem_we", mem_we, 1);
            check("st_mem_addr", mem_addr, 32'h20);
            check("st_mem_wdata", mem_wdata, 32'hCAFE);
            if (i == 2) #1 mem_ack = 1;
        end
        @(negedge clk);
        check("st_d_ready", d_ready, 1);
        check("st_d_rdata", d_rdata, 0);
        #1 d_req = 0; d_we = 0; mem_ack = 0;

        // Reset during BUSY drops the access; a later ack is ignored.
        @(negedge clk);
        #1 d_req = 1; d_addr = 32'h300;
        @(negedge clk);
        check("rb_busy", mem_req, 1);
        #1 reset = 0;
        @(negedge clk);
        check("rb_mem_req", mem_req, 0);
        #1 reset = 1; d_req = 0; mem_ack = 1;
        repeat (3) begin
            @(negedge clk);
            check("rb_no_ready", d_ready, 0);
        end
        #1 mem_ack = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog abort with a late ack afterwards.
        @(negedge clk);
        #1 if_req = 1; if_addr = 32'h400;
        busy_cnt = 0; got_err = 0;
        for (int i = 0; i < 200 && !got_err; i++) begin
            @(negedge clk);
            if (mem_req) busy_cnt++;
            if (err) got_err = 1;
        end
        check("tmo_err_seen", got_err, 1);
        check("tmo_busy_cycles", busy_cnt, TIMEOUT_CYCLES);
        check("tmo_if_ready", if_ready, 1);
        check("tmo_if_rdata", if_rdata, 32'hDEAD_BEEF);
        #1 if_req = 0; mem_ack = 1;
        @(negedge clk);
        check("tmo_err_pulse", err, 0);
        #1 mem_ack = 0;
`endif

        // Randomized traffic with the requester protocol honoured and occasional resets.
        if_pend = 0; d_pend = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (if_ready) if_pend = 0;
            if (d_ready) d_pend = 0;
            #1;
            if (!reset) reset = 1;
            else if ($urandom_range(199) == 0) reset = 0;
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1;
                if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend  = 1;
                d_we    = $urandom_range(1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if_req    = if_pend;
            d_req     = d_pend;
            mem_ack   = $urandom_range(1);
            mem_rdata = $urandom;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
